// File: rtl/lockin_sweep_ctrl_if.sv
// Result stream from the sweep controller to the readout path.
// The master side presents one averaged (x, y, idx) point per valid/ready handshake.
interface lockin_sweep_ctrl_if #(
    parameter int DATA_W = 24
);
    logic                     res_valid;
    logic                     res_ready;
    logic signed [DATA_W-1:0] res_x;
    logic signed [DATA_W-1:0] res_y;
    logic [15:0]              res_idx;

    modport master (output res_valid, res_x, res_y, res_idx, input res_ready);
    modport slave  (input res_valid, res_x, res_y, res_idx, output res_ready);
endinterface

// File: rtl/lockin_sweep_ctrl.sv
// Steps the lock-in reference through a frequency sweep.
// Each point waits out a settle time, then averages x/y, then streams the result.
module lockin_sweep_ctrl #(
    parameter int DATA_W   = 24,
    parameter int PINC_W   = 32,
    parameter int MAX_LOG2 = 15,
    parameter int ACC_W    = DATA_W + MAX_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [PINC_W-1:0]        f_start,
    input  logic [PINC_W-1:0]        f_step,
    input  logic [15:0]              n_steps,
    input  logic [23:0]              settle,
    input  logic [3:0]               avg_log2,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic [PINC_W-1:0]        cnt_inc,
    output logic                     busy,
    output logic                     done,
    lockin_sweep_ctrl_if.master      res
);

    localparam int         CNT_W    = MAX_LOG2;
    localparam logic [3:0] LOG2_MAX = 4'(MAX_LOG2);

    typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, OUTPUT, DONE} state_t;

    state_t                   state, next_state;
    logic [PINC_W-1:0]        f_step_q;
    logic [15:0]              n_steps_q;
    logic [23:0]              settle_q;
    logic [3:0]               log2_q;
    logic [3:0]               log2_in;
    logic [15:0]              idx;
    logic [23:0]              settle_cnt;
    logic [CNT_W-1:0]         acc_cnt;
    logic signed [ACC_W-1:0]  acc_x, acc_y;
    logic signed [ACC_W-1:0]  sum_x, sum_y;
    logic                     handshake;
    logic                     start_go, clear_acc, emit, advance;

    assign log2_in   = (avg_log2 > LOG2_MAX) ? LOG2_MAX : avg_log2;
    assign handshake = res.res_valid && res.res_ready;
    assign sum_x     = acc_x + ACC_W'(x_in);
    assign sum_y     = acc_y + ACC_W'(y_in);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // abort wins over everything once a sweep is running, including a pending handshake
    always_comb begin
        next_state = state;
        start_go   = 1'b0;
        clear_acc  = 1'b0;
        emit       = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort && (n_steps != 16'd0)) begin
                    next_state = SETTLE;
                    start_go   = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (settle_cnt == 24'd0) begin
                    next_state = ACCUM;
                    clear_acc  = 1'b1;
                end
            end
            ACCUM: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (acc_cnt == '0) begin
                    next_state = OUTPUT;
                    emit       = 1'b1;
                end
            end
            OUTPUT: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (handshake) begin
                    if (idx == n_steps_q - 16'd1) begin
                        next_state = DONE;
                    end else begin
                        next_state = SETTLE;
                        advance    = 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final sample is folded in on the way out so the result lands with the OUTPUT entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_inc       <= '0;
            f_step_q      <= '0;
            n_steps_q     <= '0;
            settle_q      <= '0;
            log2_q        <= '0;
            idx           <= '0;
            settle_cnt    <= '0;
            acc_cnt       <= '0;
            acc_x         <= '0;
            acc_y         <= '0;
            res.res_valid <= 1'b0;
            res.res_x     <= '0;
            res.res_y     <= '0;
            res.res_idx   <= '0;
        end else begin
            if (start_go) begin
                cnt_inc    <= f_start;
                f_step_q   <= f_step;
                n_steps_q  <= n_steps;
                settle_q   <= settle;
                log2_q     <= log2_in;
                idx        <= '0;
                settle_cnt <= settle;
            end else if (advance) begin
                cnt_inc    <= cnt_inc + f_step_q;
                idx        <= idx + 16'd1;
                settle_cnt <= settle_q;
            end else if ((state == SETTLE) && (settle_cnt != 24'd0)) begin
                settle_cnt <= settle_cnt - 24'd1;
            end

            if (clear_acc) begin
                acc_x   <= '0;
                acc_y   <= '0;
                acc_cnt <= CNT_W'((32'd1 << log2_q) - 32'd1);
            end else if (state == ACCUM) begin
                acc_x   <= sum_x;
                acc_y   <= sum_y;
                acc_cnt <= acc_cnt - CNT_W'(1);
            end

            if (emit) begin
                res.res_x   <= DATA_W'(sum_x >>> log2_q);
                res.res_y   <= DATA_W'(sum_y >>> log2_q);
                res.res_idx <= idx;
            end

            res.res_valid <= (next_state == OUTPUT);
        end
    end

endmodule
